rx_pingpong_ctrl: RTL and testbench

//  Ping-pong write controller for the 512x32 receive RAM that sits after the command/data splitter.

---
 rtl/rx_pingpong_if.sv | 43 ++++
 rtl/rx_pingpong_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_rx_pingpong_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rx_pingpong_if.sv
// Bundle of the write-side packet stream, the RAM write port and the
// reader handshake used by the receive ping-pong controller.
interface rx_pingpong_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) ();
    // Incoming data-packet word stream
    logic              in_sop;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [LEN_W-1:0]  in_len;

    // RAM write port
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    // Reader handshake
    logic              rd_ready;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_words;
    logic              rd_done;

    // Loss reporting
    logic              pkt_drop;
    logic              pkt_abort;
    logic [15:0]       drop_cnt;

    // Producer / reader side
    modport master (
        output in_sop, in_valid, in_data, in_len, rd_done,
        input  ram_we, ram_addr, ram_wdata, rd_ready, rd_bank, rd_words,
               pkt_drop, pkt_abort, drop_cnt
    );

    // Controller side
    modport slave (
        input  in_sop, in_valid, in_data, in_len, rd_done,
        output ram_we, ram_addr, ram_wdata, rd_ready, rd_bank, rd_words,
               pkt_drop, pkt_abort, drop_cnt
    );
endinterface

// File: rtl/rx_pingpong_ctrl.sv
// Ping-pong write controller for the 512x32 receive RAM. Each data packet
// is placed in one of two 256-word banks; the reader is told when a bank
// holds a complete packet and hands it back with rd_done. Packets that
// cannot be stored are dropped, truncated packets are aborted, and both
// are counted in a saturating counter.
module rx_pingpong_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rx_pingpong_if.slave  bus
);
    localparam int OFF_W = ADDR_W - 1;
    localparam int WL_W  = LEN_W + 1;
    localparam logic [WL_W-1:0] BANK_DEPTH = WL_W'(2 ** OFF_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Write FSM state
    state_t            state_r;
    state_t            state_next_s;
    logic              wr_ptr_r;
    logic              wr_ptr_next_s;
    logic [OFF_W-1:0]  offset_r;
    logic [OFF_W-1:0]  offset_next_s;
    logic [ADDR_W-1:0] words_r;
    logic [ADDR_W-1:0] words_next_s;

    // Per-cycle decisions
    logic [WL_W-1:0]   words_s;
    logic              sop_ok_s;
    logic              last_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic              drop_s;
    logic              abort_s;
    logic              cmpl_s;
    logic              store_s;

    // Registered write port and loss reporting
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;
    logic              pkt_drop_r;
    logic              pkt_abort_r;
    logic [15:0]       drop_cnt_r;
    logic [15:0]       drop_cnt_next_s;
    logic [1:0]        drop_inc_s;
    logic [16:0]       drop_sum_s;

    // Bank bookkeeping
    logic              cmpl_r;
    logic              cmpl_bank_r;
    logic [1:0]        full_r;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;
    logic [1:0]        full_next_s;
    logic              rd_ptr_r;
    logic              rd_ptr_next_s;
    logic              rd_release_s;
    logic              rd_ready_r;
    logic              rd_bank_r;
    logic [ADDR_W-1:0] rd_words_r;
    logic [ADDR_W-1:0] bank_words_r [2];

    // Word count is formed one bit wider than the length so 16'hFFFF does not wrap
    assign words_s  = ({1'b0, bus.in_len} + WL_W'(3)) >> 2;
    assign sop_ok_s = (words_s != {WL_W{1'b0}}) && (words_s <= BANK_DEPTH) && !full_r[wr_ptr_r];
    assign last_s   = ({1'b0, offset_r} == (words_r - ADDR_W'(1)));

    // Write FSM: accept, write, abort, drop or swallow the current word
    always_comb begin
        state_next_s  = state_r;
        wr_ptr_next_s = wr_ptr_r;
        offset_next_s = offset_r;
        words_next_s  = words_r;
        we_s          = 1'b0;
        addr_s        = ram_addr_r;
        drop_s        = 1'b0;
        abort_s       = 1'b0;
        cmpl_s        = 1'b0;
        store_s       = 1'b0;
        if (bus.in_valid && bus.in_sop) begin
            // A new start while still writing truncates the current packet;
            // the new packet is judged in the same cycle as if from IDLE.
            abort_s = (state_r == WRITE);
            if (sop_ok_s) begin
                we_s         = 1'b1;
                addr_s       = {wr_ptr_r, {OFF_W{1'b0}}};
                store_s      = 1'b1;
                words_next_s = words_s[ADDR_W-1:0];
                if (words_s == WL_W'(1)) begin
                    cmpl_s        = 1'b1;
                    wr_ptr_next_s = ~wr_ptr_r;
                    offset_next_s = {OFF_W{1'b0}};
                    state_next_s  = IDLE;
                end else begin
                    offset_next_s = OFF_W'(1);
                    state_next_s  = WRITE;
                end
            end else begin
                drop_s       = 1'b1;
                state_next_s = DISCARD;
            end
        end else if (bus.in_valid && (state_r == WRITE)) begin
            we_s   = 1'b1;
            addr_s = {wr_ptr_r, offset_r};
            if (last_s) begin
                cmpl_s        = 1'b1;
                wr_ptr_next_s = ~wr_ptr_r;
                offset_next_s = {OFF_W{1'b0}};
                state_next_s  = IDLE;
            end else begin
                offset_next_s = offset_r + OFF_W'(1);
            end
        end else begin
            // Stray words in IDLE/DISCARD are ignored; an illegal encoding recovers to IDLE
            case (state_r)
                IDLE:    state_next_s = IDLE;
                WRITE:   state_next_s = WRITE;
                DISCARD: state_next_s = DISCARD;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Loss counter: an abort and a drop can land in the same cycle
    always_comb begin
        drop_inc_s      = {1'b0, drop_s} + {1'b0, abort_s};
        drop_sum_s      = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
        drop_cnt_next_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    // Bank status: completion lands one cycle after the last write; release frees the read bank
    always_comb begin
        rd_release_s  = bus.rd_done && rd_ready_r;
        rd_ptr_next_s = rd_ptr_r ^ rd_release_s;
        full_set_s    = cmpl_r ? (2'b01 << cmpl_bank_r) : 2'b00;
        full_clr_s    = rd_release_s ? (2'b01 << rd_ptr_r) : 2'b00;
        full_next_s   = (full_r | full_set_s) & ~full_clr_s;
    end

    // Write FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            wr_ptr_r <= 1'b0;
            offset_r <= {OFF_W{1'b0}};
            words_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            offset_r <= offset_next_s;
            words_r  <= words_next_s;
        end
    end

    // Registered RAM write port and loss pulses/counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            pkt_drop_r  <= 1'b0;
            pkt_abort_r <= 1'b0;
            drop_cnt_r  <= 16'd0;
        end else begin
            ram_we_r    <= we_s;
            ram_addr_r  <= addr_s;
            ram_wdata_r <= we_s ? bus.in_data : ram_wdata_r;
            pkt_drop_r  <= drop_s;
            pkt_abort_r <= abort_s;
            drop_cnt_r  <= drop_cnt_next_s;
        end
    end

    // Bank occupancy, stored word counts and the reader-facing status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmpl_r          <= 1'b0;
            cmpl_bank_r     <= 1'b0;
            full_r          <= 2'b00;
            rd_ptr_r        <= 1'b0;
            rd_ready_r      <= 1'b0;
            rd_bank_r       <= 1'b0;
            rd_words_r      <= {ADDR_W{1'b0}};
            bank_words_r[0] <= {ADDR_W{1'b0}};
            bank_words_r[1] <= {ADDR_W{1'b0}};
        end else begin
            cmpl_r      <= cmpl_s;
            cmpl_bank_r <= wr_ptr_r;
            full_r      <= full_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            rd_ready_r  <= full_next_s[rd_ptr_next_s];
            rd_bank_r   <= rd_ptr_next_s;
            rd_words_r  <= full_next_s[rd_ptr_next_s] ? bank_words_r[rd_ptr_next_s]
                                                      : {ADDR_W{1'b0}};
            if (store_s) begin
                bank_words_r[wr_ptr_r] <= words_s[ADDR_W-1:0];
            end else begin
                bank_words_r[wr_ptr_r] <= bank_words_r[wr_ptr_r];
            end
        end
    end

    assign bus.ram_we    = ram_we_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.rd_ready  = rd_ready_r;
    assign bus.rd_bank   = rd_bank_r;
    assign bus.rd_words  = rd_words_r;
    assign bus.pkt_drop  = pkt_drop_r;
    assign bus.pkt_abort = pkt_abort_r;
    assign bus.drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_rx_pingpong_ctrl.sv
// Directed bench for rx_pingpong_ctrl: expected RAM writes are queued as
// stimulus is driven and checked as the write port fires.
module tb_rx_pingpong_ctrl;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rx_pingpong_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    rx_pingpong_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int drop_seen = 0;
    int abort_seen = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard and pulse counters, sampled away from the rising edge
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (bus.pkt_drop === 1'b1) drop_seen++;
        if (bus.pkt_abort === 1'b1) abort_seen++;
        if (bus.ram_we === 1'b1) begin
            // A write with nothing queued is compared against an address/data pair never used
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {ADDR_W+DATA_W{1'b1}};
            check("we_addr", 32'(bus.ram_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
            check("we_data", bus.ram_wdata, e[DATA_W-1:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_sop   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_len   = 16'd0;
        bus.rd_done  = 1'b0;
    endtask

    task automatic send(input logic [15:0] len, input int n, input logic [8:0] base,
                        input logic [31:0] seed, input bit expect_we);
        for (int i = 0; i < n; i++) begin
            bus.in_sop   = (i == 0);
            bus.in_valid = 1'b1;
            bus.in_len   = (i == 0) ? len : 16'd0;
            bus.in_data  = seed + 32'(i);
            if (expect_we) exp_q.push_back({base + 9'(i), seed + 32'(i)});
            tick();
        end
        idle_inputs();
    endtask

    task automatic release_bank();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic ready, input logic bank, input int words);
        check({tag, "_ready"}, 32'(bus.rd_ready), 32'(ready));
        check({tag, "_bank"}, 32'(bus.rd_bank), 32'(bank));
        check({tag, "_words"}, 32'(bus.rd_words), 32'(words));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, 32'(bus.ram_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_wdata"}, bus.ram_wdata, 32'd0);
        check({tag, "_drop"}, 32'(bus.pkt_drop), 32'd0);
        check({tag, "_abort"}, 32'(bus.pkt_abort), 32'd0);
        check({tag, "_cnt"}, 32'(bus.drop_cnt), 32'd0);
        check_rd(tag, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Stray word outside a packet must not write
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hBAD0_0001;
        tick();
        idle_inputs();
        tick();

        // T1: 40 bytes -> 10 words into bank 0; ready one cycle after the last write
        send(16'd40, 10, 9'd0, 32'hD100_0000, 1'b1);
        check("t1_ready_latency", 32'(bus.rd_ready), 32'd0);
        tick();
        check_rd("t1", 1'b1, 1'b0, 10);

        // T2: 8 bytes -> bank 1; release bank 0 exposes bank 1
        send(16'd8, 2, 9'd256, 32'hD200_0000, 1'b1);
        tick();
        tick();
        check_rd("t2_hold", 1'b1, 1'b0, 10);
        release_bank();
        check_rd("t2", 1'b1, 1'b1, 2);

        // T3: refill bank 0, then both full -> drop; release bank 1 and reuse it
        send(16'd4, 1, 9'd0, 32'hD300_0000, 1'b1);
        tick();
        send(16'd8, 2, 9'd0, 32'hD3F0_0000, 1'b0);
        tick();
        check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        check("t3_drop_pulses", 32'(drop_seen), 32'd1);
        release_bank();
        check_rd("t3_rel", 1'b1, 1'b0, 1);
        send(16'd12, 3, 9'd256, 32'hD310_0000, 1'b1);
        tick();
        release_bank();
        check_rd("t3_b1", 1'b1, 1'b1, 3);
        release_bank();
        check_rd("t3_empty", 1'b0, 1'b0, 0);

        // T4: zero length and 257 words are both dropped
        send(16'd0, 1, 9'd0, 32'hD400_0000, 1'b0);
        send(16'd1028, 2, 9'd0, 32'hD410_0000, 1'b0);
        tick();
        tick();
        check("t4_drop_cnt", 32'(bus.drop_cnt), 32'd3);
        check("t4_drop_pulses", 32'(drop_seen), 32'd3);
        check("t4_ready", 32'(bus.rd_ready), 32'd0);

        // Largest packet: 1021 bytes round up to 256 words filling bank 0
        send(16'd1021, 256, 9'd0, 32'hD500_0000, 1'b1);
        tick();
        check_rd("max", 1'b1, 1'b0, 256);
        release_bank();

        // T5: truncated by a new start; the new 1-word packet reuses the bank
        send(16'd40, 3, 9'd256, 32'hD600_0000, 1'b1);
        send(16'd4, 1, 9'd256, 32'hD610_0000, 1'b1);
        tick();
        check("t5_abort_pulses", 32'(abort_seen), 32'd1);
        check("t5_drop_cnt", 32'(bus.drop_cnt), 32'd4);
        check_rd("t5", 1'b1, 1'b1, 1);
        release_bank();

        // T6: reset in the middle of a packet clears everything
        send(16'd20, 2, 9'd0, 32'hD700_0000, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("t6_reset");
        send(16'd8, 2, 9'd0, 32'hD710_0000, 1'b1);
        tick();
        check_rd("t6", 1'b1, 1'b0, 2);
        check("t6_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        tick();
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_drop_pulses", 32'(drop_seen), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
